// File: rtl/turfio_gen_shift_sequencer_if.sv
// Command/response stream plus Wishbone classic master bundle
// for the TURFIO shift-register sequencer.
interface turfio_gen_shift_sequencer_if #(
    parameter int ADR_W = 12
);
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [1:0]       cmd_op_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [31:0]      cmd_dat_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_dat_o;
    logic [1:0]       rsp_status_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_we_o;
    logic [3:0]       wb_sel_o;
    logic [ADR_W-1:0] wb_adr_o;
    logic [31:0]      wb_dat_o;
    logic [31:0]      wb_dat_i;
    logic             wb_ack_i;
    logic             wb_err_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_status_o,
        input  rsp_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        output wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_status_o,
        output rsp_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        input  wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/turfio_gen_shift_sequencer.sv
// Command-driven Wishbone master: WRITE/READ/POLL/DELAY commands,
// one single-beat access at a time, one response per command.
module turfio_gen_shift_sequencer #(
    parameter int ADR_W       = 12,
    parameter int POLL_GAP    = 16,
    parameter int MAX_POLLS   = 1024,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n_i,
    turfio_gen_shift_sequencer_if.master bus
);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_POLL = 2'd2;
    localparam logic [1:0] OP_DLY  = 2'd3;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_ATO = 2'd2;
    localparam logic [1:0] ST_PTO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_BUS, S_GAP, S_DLY, S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [15:0]      dly_q, dly_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [PW-1:0]    pol_q, pol_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [1:0]       st_q, st_d;
    logic [1:0]       sync_q;

    // Reset asserts at once but is released only after two clocks.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) sync_q <= 2'b00;
        else             sync_q <= {sync_q[0], 1'b1};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_WR;
            adr_q   <= '0;
            dat_q   <= '0;
            dly_q   <= '0;
            gap_q   <= '0;
            wd_q    <= '0;
            pol_q   <= '0;
            rdat_q  <= '0;
            st_q    <= ST_OK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            dly_q   <= dly_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            pol_q   <= pol_d;
            rdat_q  <= rdat_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        dly_d   = dly_q;
        gap_d   = gap_q;
        wd_d    = wd_q;
        pol_d   = pol_q;
        rdat_d  = rdat_q;
        st_d    = st_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i && sync_q[1]) begin
                    op_d   = bus.cmd_op_i;
                    adr_d  = bus.cmd_adr_i;
                    dat_d  = bus.cmd_dat_i;
                    dly_d  = bus.cmd_dat_i[15:0];
                    pol_d  = '0;
                    wd_d   = '0;
                    rdat_d = '0;
                    st_d   = ST_OK;
                    if (bus.cmd_op_i != OP_DLY)
                        state_d = S_BUS;
                    else if (bus.cmd_dat_i[15:0] == 16'd0)
                        state_d = S_RESP;
                    else
                        state_d = S_DLY;
                end
            end
            S_BUS: begin
                if (bus.wb_err_i) begin
                    rdat_d  = '0;
                    st_d    = ST_ERR;
                    state_d = S_RESP;
                end else if (bus.wb_ack_i) begin
                    state_d = S_RESP;
                    if (op_q == OP_POLL) begin
                        rdat_d = bus.wb_dat_i;
                        pol_d  = pol_q + 1'b1;
                        if ((bus.wb_dat_i & dat_q) == 32'd0) begin
                            st_d = ST_OK;
                        end else if (pol_d == PW'(MAX_POLLS)) begin
                            st_d = ST_PTO;
                        end else begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end else begin
                        rdat_d = (op_q == OP_RD) ? bus.wb_dat_i : '0;
                    end
                end else if (wd_q == WW'(ACK_TIMEOUT - 1)) begin
                    rdat_d  = '0;
                    st_d    = ST_ATO;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    wd_d    = '0;
                    state_d = S_BUS;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DLY: begin
                if (dly_q <= 16'd1) state_d = S_RESP;
                else                dly_d = dly_q - 1'b1;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready_o  = (state_q == S_IDLE) && sync_q[1];
    assign bus.rsp_valid_o  = (state_q == S_RESP);
    assign bus.rsp_dat_o    = rdat_q;
    assign bus.rsp_status_o = st_q;
    assign bus.wb_cyc_o     = (state_q == S_BUS);
    assign bus.wb_stb_o     = (state_q == S_BUS);
    assign bus.wb_we_o      = (state_q == S_BUS) && (op_q == OP_WR);
    assign bus.wb_sel_o     = (state_q == S_BUS) ? 4'hF : 4'h0;
    assign bus.wb_adr_o     = adr_q;
    assign bus.wb_dat_o     = dat_q;
endmodule
